control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ir  in  16  instruction register contents; opcode = ir[15:12].
REQ-005 z  in  1  accumulator-zero flag from ALU.
REQ-006 bus_sel  out  4  bus source select: 0 none, 1 AR, 2 AC, 3 PC, 4 DR, 5 R, 6 IRAM, 7 DRAM.
REQ-007 ar_ld, pc_ld, pc_inc, ir_ld, dr_ld, r_ld, ac_ld  out  1 each  register load/increment strobes (PC/AR/IR/DR/R/AC load from bus).
REQ-008 dram_we  out  1  data-RAM write strobe; DRAM[AR] <= bus.
REQ-009 alu_op  out  3  0 PASS, 1 ADD, 2 SUB, 3 INC, 4 CLR.
REQ-010 halted  out  1  high while in HALT state.
REQ-011 instr_count  out  16  number of completed instructions.

Function
REQ-012 Moore FSM; all outputs except instr_count SHALL be a combinational function of the current state only; strobes and alu_op not listed for a state are 0.
REQ-013 START: all outputs 0; next FETCH1.
REQ-014 FETCH1: bus_sel=3, ar_ld. FETCH2: bus_sel=6, ir_ld, pc_inc. DECODE: bus_sel=0; branch on ir[15:12] sampled this cycle.
REQ-015 Opcodes: 0 NOP, 1 LDAC, 2 STAC, 3 MVACR, 4 MVRAC, 5 ADD, 6 SUB, 7 INC, 8 CLAC, 9 JUMP, A JMPZ, F HALT; B-E SHALL execute as NOP.
REQ-016 NOP: DECODE -> FETCH1 directly.
REQ-017 LDAC: OP1 (bus 3, ar_ld); OP2 (bus 6, dr_ld, pc_inc); OP3 (bus 4, ar_ld); LD4 (bus 7, dr_ld); LD5 (bus 4, ac_ld, alu_op=PASS) -> FETCH1.
REQ-018 STAC: OP1, OP2, OP3 as LDAC; ST4 (bus 2, dram_we) -> FETCH1.
REQ-019 MVACR: bus 2, r_ld. MVRAC: bus 5, ac_ld, PASS. ADD: bus 5, ac_ld, ADD. SUB: bus 5, ac_ld, SUB. INC: bus 0, ac_ld, INC. CLAC: bus 0, ac_ld, CLR. Each is one state -> FETCH1.
REQ-020 JUMP: J1 (bus 3, ar_ld); J2 (bus 6, pc_ld) -> FETCH1.
REQ-021 JMPZ: in DECODE, z=1 -> J1; z=0 -> JSKIP (pc_inc only) -> FETCH1.
REQ-022 HALT: halted=1, all other outputs 0; state held until rst.
REQ-023 Cycle counts from FETCH1 to next FETCH1: NOP 3, register ops 4, LDAC 8, STAC 7, JUMP/JMPZ-taken 5, JMPZ-not-taken 4.
REQ-024 instr_count SHALL increment by 1 on the clock edge leaving the last state of each instruction (including NOP, excluding HALT) and wrap 0xFFFF -> 0x0000.
REQ-025 At most one of ar_ld, pc_ld, ir_ld, dr_ld, r_ld, ac_ld, dram_we SHALL be high in any state; pc_ld and pc_inc never together.
REQ-026 Unreachable state encodings SHALL go to START on the next edge.

Reset
REQ-027 rst=1 at a clock edge SHALL put the state in START and clear instr_count to 0, in any state, including mid-instruction and HALT.
REQ-028 Cycle after reset release: START outputs (all 0); following cycle FETCH1.

Verification
REQ-029 Reset, then ir=0x0000 (NOP) held -> bus_sel sequence 0,3,6,0,3,...; instr_count=1 after 4th post-reset edge.
REQ-030 ir=0x1000 (LDAC) -> bus_sel 3,6,0,3,6,4,7,4 with strobes per REQ-017; ac_ld with alu_op=0 in cycle 8; instr_count +1.
REQ-031 ir=0xA000 with z=0 -> JSKIP with pc_inc=1, pc_ld never high; repeat with z=1 -> J2 with bus_sel=6, pc_ld=1.
REQ-032 ir=0xF000 -> halted=1 from cycle after DECODE, held 20+ cycles with ir changing; rst=1 -> halted=0 and instr_count=0.
REQ-033 rst asserted during LD4 -> next cycle START (all outputs 0), no dr_ld/ac_ld afterwards until FETCH1.
REQ-034 Force instr_count near 0xFFFF via 65535 NOPs -> next NOP completion gives 0x0000.

Source files
------------

// File: rtl/control_unit.sv
// Microcoded-style Moore control unit for the accumulator CPU.
// Sequences fetch/decode/execute states and counts completed instructions.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        z,
  output logic [3:0]  bus_sel,
  output logic        ar_ld,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic        dr_ld,
  output logic        r_ld,
  output logic        ac_ld,
  output logic        dram_we,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_INC  = 3'd3;
  localparam logic [2:0] ALU_CLR  = 3'd4;

  localparam logic [3:0] BUS_NONE = 4'd0;
  localparam logic [3:0] BUS_AR   = 4'd1;
  localparam logic [3:0] BUS_AC   = 4'd2;
  localparam logic [3:0] BUS_PC   = 4'd3;
  localparam logic [3:0] BUS_DR   = 4'd4;
  localparam logic [3:0] BUS_R    = 4'd5;
  localparam logic [3:0] BUS_IRAM = 4'd6;
  localparam logic [3:0] BUS_DRAM = 4'd7;

  // LDAC and STAC use separate operand-fetch chains so the opcode need not be latched.
  typedef enum logic [4:0] {
    S_START, S_FETCH1, S_FETCH2, S_DECODE,
    S_LOP1, S_LOP2, S_LOP3, S_LD4, S_LD5,
    S_SOP1, S_SOP2, S_SOP3, S_ST4,
    S_MVACR, S_MVRAC, S_ADD, S_SUB, S_INC, S_CLAC,
    S_J1, S_J2, S_JSKIP, S_HALT
  } state_t;

  state_t state, next_state;
  logic   done;
  logic   unused_ir_bits;

  assign unused_ir_bits = ^ir[11:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_START;
      instr_count <= 16'h0000;
    end else begin
      state       <= next_state;
      instr_count <= instr_count + {15'd0, done};
    end
  end

  always_comb begin
    next_state = S_START;
    done       = 1'b0;
    bus_sel    = BUS_NONE;
    ar_ld      = 1'b0;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    ir_ld      = 1'b0;
    dr_ld      = 1'b0;
    r_ld       = 1'b0;
    ac_ld      = 1'b0;
    dram_we    = 1'b0;
    alu_op     = ALU_PASS;
    halted     = 1'b0;
    case (state)
      S_START:  next_state = S_FETCH1;
      S_FETCH1: begin bus_sel = BUS_PC;   ar_ld = 1'b1; next_state = S_FETCH2; end
      S_FETCH2: begin bus_sel = BUS_IRAM; ir_ld = 1'b1; pc_inc = 1'b1; next_state = S_DECODE; end
      S_DECODE: begin
        case (ir[15:12])
          4'h1: next_state = S_LOP1;
          4'h2: next_state = S_SOP1;
          4'h3: next_state = S_MVACR;
          4'h4: next_state = S_MVRAC;
          4'h5: next_state = S_ADD;
          4'h6: next_state = S_SUB;
          4'h7: next_state = S_INC;
          4'h8: next_state = S_CLAC;
          4'h9: next_state = S_J1;
          4'hA: next_state = z ? S_J1 : S_JSKIP;
          4'hF: next_state = S_HALT;
          default: begin next_state = S_FETCH1; done = 1'b1; end
        endcase
      end
      S_LOP1:  begin bus_sel = BUS_PC;   ar_ld = 1'b1; next_state = S_LOP2; end
      S_LOP2:  begin bus_sel = BUS_IRAM; dr_ld = 1'b1; pc_inc = 1'b1; next_state = S_LOP3; end
      S_LOP3:  begin bus_sel = BUS_DR;   ar_ld = 1'b1; next_state = S_LD4; end
      S_LD4:   begin bus_sel = BUS_DRAM; dr_ld = 1'b1; next_state = S_LD5; end
      S_LD5:   begin bus_sel = BUS_DR;   ac_ld = 1'b1; alu_op = ALU_PASS; next_state = S_FETCH1; done = 1'b1; end
      S_SOP1:  begin bus_sel = BUS_PC;   ar_ld = 1'b1; next_state = S_SOP2; end
      S_SOP2:  begin bus_sel = BUS_IRAM; dr_ld = 1'b1; pc_inc = 1'b1; next_state = S_SOP3; end
      S_SOP3:  begin bus_sel = BUS_DR;   ar_ld = 1'b1; next_state = S_ST4; end
      S_ST4:   begin bus_sel = BUS_AC;   dram_we = 1'b1; next_state = S_FETCH1; done = 1'b1; end
      S_MVACR: begin bus_sel = BUS_AC;   r_ld = 1'b1; next_state = S_FETCH1; done = 1'b1; end
      S_MVRAC: begin bus_sel = BUS_R;    ac_ld = 1'b1; alu_op = ALU_PASS; next_state = S_FETCH1; done = 1'b1; end
      S_ADD:   begin bus_sel = BUS_R;    ac_ld = 1'b1; alu_op = ALU_ADD;  next_state = S_FETCH1; done = 1'b1; end
      S_SUB:   begin bus_sel = BUS_R;    ac_ld = 1'b1; alu_op = ALU_SUB;  next_state = S_FETCH1; done = 1'b1; end
      S_INC:   begin bus_sel = BUS_NONE; ac_ld = 1'b1; alu_op = ALU_INC;  next_state = S_FETCH1; done = 1'b1; end
      S_CLAC:  begin bus_sel = BUS_NONE; ac_ld = 1'b1; alu_op = ALU_CLR;  next_state = S_FETCH1; done = 1'b1; end
      S_J1:    begin bus_sel = BUS_PC;   ar_ld = 1'b1; next_state = S_J2; end
      S_J2:    begin bus_sel = BUS_IRAM; pc_ld = 1'b1; next_state = S_FETCH1; done = 1'b1; end
      S_JSKIP: begin pc_inc = 1'b1; next_state = S_FETCH1; done = 1'b1; end
      S_HALT:  begin halted = 1'b1; next_state = S_HALT; end
      default: next_state = S_START;
    endcase
  end

  // BUS_AR is a legal source for other units but no state of this sequencer selects it.
  logic unused_bus_ar;
  assign unused_bus_ar = ^BUS_AR;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction micro-step table predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir  = 16'h0000;
  logic        z   = 1'b0;
  logic [3:0]  bus_sel;
  logic        ar_ld, pc_ld, pc_inc, ir_ld, dr_ld, r_ld, ac_ld, dram_we;
  logic [2:0]  alu_op;
  logic        halted;
  logic [15:0] instr_count;

  control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .z(z),
    .bus_sel(bus_sel), .ar_ld(ar_ld), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .ir_ld(ir_ld), .dr_ld(dr_ld), .r_ld(r_ld), .ac_ld(ac_ld),
    .dram_we(dram_we), .alu_op(alu_op), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Strobe mask bits: {dram_we, ac_ld, r_ld, dr_ld, ir_ld, pc_inc, pc_ld, ar_ld}
  localparam logic [7:0] M_AR = 8'h01, M_PL = 8'h02, M_PI = 8'h04, M_IR = 8'h08;
  localparam logic [7:0] M_DR = 8'h10, M_R  = 8'h20, M_AC = 8'h40, M_WE = 8'h80;

  typedef struct packed {
    logic [3:0]  bus;
    logic [7:0]  mask;
    logic [2:0]  alu;
    logic        halted;
    logic [15:0] count;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        plan[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_count = 16'h0000;
  bit          force_pending = 1'b0;
  logic [15:0] force_value = 16'h0000;

  function automatic obs_t mk(input logic [3:0] b, input logic [7:0] m,
                              input logic [2:0] a, input logic h);
    obs_t o;
    o.bus = b; o.mask = m; o.alu = a; o.halted = h; o.count = 16'h0000;
    return o;
  endfunction

  // Reference: the micro-steps each opcode walks through, FETCH1 first.
  task automatic build_plan(input logic [3:0] op, input logic zv);
    plan.delete();
    plan.push_back(mk(4'd3, M_AR, 3'd0, 1'b0));
    plan.push_back(mk(4'd6, M_IR | M_PI, 3'd0, 1'b0));
    plan.push_back(mk(4'd0, 8'h00, 3'd0, 1'b0));
    case (op)
      4'h1, 4'h2: begin
        plan.push_back(mk(4'd3, M_AR, 3'd0, 1'b0));
        plan.push_back(mk(4'd6, M_DR | M_PI, 3'd0, 1'b0));
        plan.push_back(mk(4'd4, M_AR, 3'd0, 1'b0));
        if (op == 4'h1) begin
          plan.push_back(mk(4'd7, M_DR, 3'd0, 1'b0));
          plan.push_back(mk(4'd4, M_AC, 3'd0, 1'b0));
        end else begin
          plan.push_back(mk(4'd2, M_WE, 3'd0, 1'b0));
        end
      end
      4'h3: plan.push_back(mk(4'd2, M_R,  3'd0, 1'b0));
      4'h4: plan.push_back(mk(4'd5, M_AC, 3'd0, 1'b0));
      4'h5: plan.push_back(mk(4'd5, M_AC, 3'd1, 1'b0));
      4'h6: plan.push_back(mk(4'd5, M_AC, 3'd2, 1'b0));
      4'h7: plan.push_back(mk(4'd0, M_AC, 3'd3, 1'b0));
      4'h8: plan.push_back(mk(4'd0, M_AC, 3'd4, 1'b0));
      4'h9, 4'hA: begin
        if (op == 4'h9 || zv) begin
          plan.push_back(mk(4'd3, M_AR, 3'd0, 1'b0));
          plan.push_back(mk(4'd6, M_PL, 3'd0, 1'b0));
        end else begin
          plan.push_back(mk(4'd0, M_PI, 3'd0, 1'b0));
        end
      end
      4'hF: repeat (25) plan.push_back(mk(4'd0, 8'h00, 3'd0, 1'b1));
      default: ;
    endcase
  endtask

  task automatic push_cycle(input obs_t e);
    obs_t x;
    x = e;
    x.count = model_count;
    exp_q.push_back(x);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_count = 16'h0000;
    push_cycle(mk(4'd0, 8'h00, 3'd0, 1'b0));
  endtask

  // Runs one instruction from FETCH1; abort_at >= 0 asserts rst during that step.
  task automatic applyStimulus(input logic [3:0] op, input logic zv, input int abort_at);
    int stop;
    bit aborted;
    build_plan(op, zv);
    stop = (op == 4'hF) ? plan.size() - 1 : abort_at;
    aborted = 1'b0;
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        ir = {op, 12'($urandom)};
        z  = zv;
      end else begin
        ir = 16'($urandom);
        z  = 1'($urandom);
      end
      if (force_pending && i == 0) begin
        force dut.instr_count = force_value;
        model_count = force_value;
      end
      if (force_pending && i == 1) begin
        release dut.instr_count;
        force_pending = 1'b0;
      end
      rst = (i == stop);
      push_cycle(plan[i]);
      if (i == stop) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_count = 16'h0000;
      push_cycle(mk(4'd0, 8'h00, 3'd0, 1'b0));
    end else begin
      model_count = model_count + 16'd1;
    end
  endtask

  task automatic checkOutput(input obs_t act, input obs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL cycle_outputs t=%0t: got bus=%0d strobes=%02h alu=%0d halted=%0b count=%04h, expected bus=%0d strobes=%02h alu=%0d halted=%0b count=%04h",
               $time, act.bus, act.mask, act.alu, act.halted, act.count,
               e.bus, e.mask, e.alu, e.halted, e.count);
    end
    checks++;
    if ($countones(act.mask & ~M_PI) > 1 || (act.mask[1] && act.mask[2])) begin
      errors++;
      $display("[TB] FAIL strobe_exclusive t=%0t: got strobes=%02h, expected at most one load and not pc_ld with pc_inc",
               $time, act.mask);
    end
  endtask

  always @(negedge clk) begin
    obs_t act;
    obs_t e;
    act = {bus_sel, {dram_we, ac_ld, r_ld, dr_ld, ir_ld, pc_inc, pc_ld, ar_ld},
           alu_op, halted, instr_count};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(act, e);
    end
  end

  initial begin
    $display("[TB] control_unit scoreboard bench starting");
    reset_dut();

    repeat (4) applyStimulus(4'h0, 1'b0, -1);

    for (int o = 1; o < 15; o++)
      for (int zz = 0; zz < 2; zz++)
        applyStimulus(4'(o), 1'(zz), -1);

    // Reset landing in LD4 must cancel the load and the count.
    applyStimulus(4'h1, 1'b0, 6);
    applyStimulus(4'h0, 1'b0, -1);

    repeat (300) applyStimulus(4'($urandom_range(0, 14)), 1'($urandom), -1);

    repeat (12) applyStimulus(4'($urandom_range(0, 14)), 1'($urandom),
                              int'($urandom_range(0, 7)));

    // Jump the counter close to its limit, then let NOPs carry it over the wrap.
    force_value   = 16'hFFFD;
    force_pending = 1'b1;
    repeat (4) applyStimulus(4'h0, 1'b0, -1);
    applyStimulus(4'h1, 1'b1, -1);

    applyStimulus(4'hF, 1'b0, -1);
    applyStimulus(4'h0, 1'b0, -1);
    applyStimulus(4'h5, 1'b0, -1);

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
